acc_store_ctrl: RTL and testbench

ACC_STORE_CTRL -- requirements
Module: acc_store_ctrl

---
 rtl/cpu_pkg.sv | 15 +
 rtl/acc_store_ctrl_if.sv | 25 ++
 rtl/acc_store_ctrl_wait_timer.sv | 24 ++
 rtl/acc_store_ctrl.sv | 88 ++++++++
 tb/tb_acc_store_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants and the store-controller state encoding.
package cpu_pkg;
  localparam int ACC_W       = 16;
  localparam int BYTE_W      = 8;
  localparam int WAIT_W      = 8;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_LO,
    ST_WR_HI,
    ST_DONE,
    ST_ERR
  } store_st_e;
endpackage

// File: rtl/acc_store_ctrl_if.sv
// Accumulator-store bus: CPU-side request/status plus the byte-wide memory port.
interface acc_store_ctrl_if #(parameter int ADDR_W = 12);
  import cpu_pkg::*;

  logic                store_req;
  logic [ADDR_W-1:0]   store_addr;
  logic [ACC_W-1:0]    acc_val;
  logic                mem_ready;
  logic                mem_we;
  logic [ADDR_W:0]     mem_addr;
  logic [BYTE_W-1:0]   mem_wdata;
  logic                store_busy;
  logic                store_done;
  logic                store_err;

  modport master (
    output store_req, store_addr, acc_val, mem_ready,
    input  mem_we, mem_addr, mem_wdata, store_busy, store_done, store_err
  );

  modport slave (
    input  store_req, store_addr, acc_val, mem_ready,
    output mem_we, mem_addr, mem_wdata, store_busy, store_done, store_err
  );
endinterface

// File: rtl/acc_store_ctrl_wait_timer.sv
// Loadable 8-bit up-counter with clear and terminal-count compare.
module wait_timer
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [WAIT_W-1:0] ld_val,
  input  logic              clr,
  input  logic              inc,
  input  logic [WAIT_W-1:0] tc_val,
  output logic              tc
);
  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (ld)  cnt <= ld_val;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == tc_val);
endmodule

// File: rtl/acc_store_ctrl.sv
// Writes the 16-bit accumulator to byte-wide memory as two beats (low, high)
// with a per-beat wait timeout.
module acc_store_ctrl
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  acc_store_ctrl_if.slave   bus
);
  localparam logic [WAIT_W-1:0] TC_VAL = WAIT_W'(TIMEOUT);

  store_st_e          st;
  logic [ACC_W-1:0]   data_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               in_wr, beat, accept, tc;

  logic               mem_we;
  logic [ADDR_W:0]    mem_addr;
  logic [BYTE_W-1:0]  mem_wdata;

  assign in_wr  = (st == ST_WR_LO) || (st == ST_WR_HI);
  assign beat   = in_wr && bus.mem_ready;
  assign accept = (st == ST_IDLE) && bus.store_req;

  wait_timer u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .ld     (accept),
    .ld_val ('0),
    .clr    (beat),
    .inc    (in_wr && !bus.mem_ready),
    .tc_val (TC_VAL),
    .tc     (tc)
  );

  // Requests are only looked at in IDLE; DONE/ERR always fall back to IDLE,
  // so a held request is taken one cycle after the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= ST_IDLE;
      data_q <= '0;
      addr_q <= '0;
    end else begin
      unique case (st)
        ST_IDLE: if (bus.store_req) begin
          data_q <= bus.acc_val;
          addr_q <= bus.store_addr;
          st     <= ST_WR_LO;
        end
        ST_WR_LO: if (bus.mem_ready) st <= ST_WR_HI;
                  else if (tc)       st <= ST_ERR;
        ST_WR_HI: if (bus.mem_ready) st <= ST_DONE;
                  else if (tc)       st <= ST_ERR;
        default:  st <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode from state and capture registers only, so reset clears them at once.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (st)
      ST_WR_LO: begin
        mem_we    = 1'b1;
        mem_addr  = {addr_q, 1'b0};
        mem_wdata = data_q[7:0];
      end
      ST_WR_HI: begin
        mem_we    = 1'b1;
        mem_addr  = {addr_q, 1'b1};
        mem_wdata = data_q[15:8];
      end
      default: ;
    endcase
  end

  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.store_busy = (st != ST_IDLE);
  assign bus.store_done = (st == ST_DONE);
  assign bus.store_err  = (st == ST_ERR);
endmodule

// File: tb/tb_acc_store_ctrl.sv
// Scoreboard bench for acc_store_ctrl: stimulus pushes expected beats/events,
// a negedge monitor pops and compares them.
module tb_acc_store_ctrl;
  import cpu_pkg::*;

  localparam int ADDR_W = 12;

  typedef struct packed {
    logic [ADDR_W:0] addr;
    logic [7:0]      data;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  acc_store_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  acc_store_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  beat_t      exp_beat[$];
  logic [1:0] exp_evt[$];   // {done, err}
  int         done_cyc[$];
  int errors = 0, checks = 0;
  int done_cnt = 0, err_cnt = 0;
  int wait_lo = 0, wait_hi = 0, wcnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h expected nothing", nm, act);
  endtask

  // Memory responder: hold mem_ready low for wait_lo/wait_hi cycles of each beat.
  always @(posedge clk) begin
    #1;
    if (bus.mem_we) begin
      if (wcnt >= (bus.mem_addr[0] ? wait_hi : wait_lo)) begin
        bus.mem_ready = 1'b1;
        wcnt = 0;
      end else begin
        bus.mem_ready = 1'b0;
        wcnt++;
      end
    end else begin
      bus.mem_ready = 1'b0;
      wcnt = 0;
    end
  end

  // Monitor: every cycle with mem_we must show the expected front beat.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_we) begin
        if (exp_beat.size() == 0) fail_now("beat_unexp", {bus.mem_addr, bus.mem_wdata});
        else begin
          chk("beat_addr", bus.mem_addr, exp_beat[0].addr);
          chk("beat_data", bus.mem_wdata, exp_beat[0].data);
          if (bus.mem_ready) void'(exp_beat.pop_front());
        end
      end
      if (bus.store_done || bus.store_err) begin
        done_cnt += bus.store_done;
        err_cnt  += bus.store_err;
        if (exp_evt.size() == 0) fail_now("evt_unexp", {bus.store_done, bus.store_err});
        else chk("evt_kind", {bus.store_done, bus.store_err}, exp_evt.pop_front());
      end
    end
  end

  function automatic logic [31:0] all_out();
    return {bus.mem_we, bus.mem_addr, bus.mem_wdata,
            bus.store_busy, bus.store_done, bus.store_err};
  endfunction

  // One store; lat counts cycles from the accepting edge to the done/err cycle.
  task automatic store(input string nm, input logic [11:0] a, input logic [15:0] v,
                       input int lat, input logic [1:0] evt, input int poke);
    int n;
    bus.store_addr = a;
    bus.acc_val    = v;
    bus.store_req  = 1'b1;
    @(posedge clk); #2;
    bus.store_req = 1'b0;
    n = 1;
    while (!(bus.store_done || bus.store_err) && n < 200) begin
      if (poke != 0 && n == poke) begin
        bus.store_req  = 1'b1;
        bus.acc_val    = 16'hFFFF;
        bus.store_addr = 12'h555;
      end else bus.store_req = 1'b0;
      @(posedge clk); #2;
      n++;
    end
    bus.store_req = 1'b0;
    chk({nm, "_lat"}, n, lat);
    chk({nm, "_evt"}, {bus.store_done, bus.store_err}, evt);
    @(posedge clk); #2;
    chk({nm, "_idle"}, all_out(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.store_req  = 1'b0;
    bus.store_addr = '0;
    bus.acc_val    = '0;
    bus.mem_ready  = 1'b0;
    #1;
    chk("rst_out", all_out(), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #2;
    chk("rst_rel_out", all_out(), 0);

    // Zero-wait store
    wait_lo = 0; wait_hi = 0;
    exp_beat.push_back('{13'h020, 8'h5A});
    exp_beat.push_back('{13'h021, 8'hA5});
    exp_evt.push_back(2'b10);
    store("basic", 12'h010, 16'hA55A, 3, 2'b10, 0);

    // Three wait cycles per beat
    wait_lo = 3; wait_hi = 3;
    exp_beat.push_back('{13'h0556, 8'h34});
    exp_beat.push_back('{13'h0557, 8'h12});
    exp_evt.push_back(2'b10);
    store("wait3", 12'h2AB, 16'h1234, 9, 2'b10, 0);

    // Timeout in WR_LO: 16 cycles in WR_LO, ERR on the 17th
    wait_lo = 1000; wait_hi = 1000;
    exp_beat.push_back('{13'h01E0, 8'hEF});
    exp_evt.push_back(2'b01);
    store("to_lo", 12'h0F0, 16'hBEEF, 17, 2'b01, 0);
    chk("to_lo_left", exp_beat.size(), 1);
    exp_beat.delete();

    // Timeout in WR_HI after a good low beat
    wait_lo = 0; wait_hi = 1000;
    exp_beat.push_back('{13'h0FFE, 8'hA6});
    exp_beat.push_back('{13'h0FFF, 8'hC3});
    exp_evt.push_back(2'b01);
    store("to_hi", 12'h7FF, 16'hC3A6, 18, 2'b01, 0);
    chk("to_hi_left", exp_beat.size(), 1);
    exp_beat.delete();

    // Second request during WR_HI with new acc_val is ignored
    wait_lo = 0; wait_hi = 0;
    exp_beat.push_back('{13'h0200, 8'h21});
    exp_beat.push_back('{13'h0201, 8'h43});
    exp_evt.push_back(2'b10);
    store("busy_req", 12'h100, 16'h4321, 3, 2'b10, 2);
    repeat (4) @(posedge clk);
    #2;

    // Held request: ignored in DONE, re-accepted in the next IDLE cycle
    for (int k = 0; k < 2; k++) begin
      exp_beat.push_back('{13'h0014, 8'h0F});
      exp_beat.push_back('{13'h0015, 8'hF0});
      exp_evt.push_back(2'b10);
    end
    bus.store_addr = 12'h00A;
    bus.acc_val    = 16'hF00F;
    bus.store_req  = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #2;
      if (n == 5) bus.store_req = 1'b0;
      if (bus.store_done) done_cyc.push_back(n);
    end
    chk("held_cnt", done_cyc.size(), 2);
    if (done_cyc.size() == 2) begin
      chk("held_first", done_cyc[0], 3);
      chk("held_second", done_cyc[1], 7);
    end

    // Reset mid WR_HI wait
    wait_lo = 0; wait_hi = 1000;
    exp_beat.push_back('{13'h0642, 8'h81});
    exp_beat.push_back('{13'h0643, 8'h7E});
    bus.store_addr = 12'h321;
    bus.acc_val    = 16'h7E81;
    bus.store_req  = 1'b1;
    @(posedge clk); #2;
    bus.store_req = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_pre_busy", {bus.store_busy, bus.mem_we, bus.mem_addr}, {2'b11, 13'h0643});
    rst = 1'b1;
    #1;
    chk("rst_async", all_out(), 0);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_mid_left", exp_beat.size(), 1);
    exp_beat.delete();
    rst = 1'b0;
    @(posedge clk); #2;
    chk("rst_mid_rel", all_out(), 0);

    wait_lo = 0; wait_hi = 0;
    exp_beat.push_back('{13'h1FFE, 8'h01});
    exp_beat.push_back('{13'h1FFF, 8'h00});
    exp_evt.push_back(2'b10);
    store("after_rst", 12'hFFF, 16'h0001, 3, 2'b10, 0);

    repeat (4) @(posedge clk);
    #2;
    chk("beat_q_empty", exp_beat.size(), 0);
    chk("evt_q_empty", exp_evt.size(), 0);
    chk("done_total", done_cnt, 6);
    chk("err_total", err_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
